// File: rtl/cnn_kernel_pkg.sv
// Shared constants, word-count helper and loader state encoding for the filter kernel-load path.
package cnn_kernel_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_KSIZE      = 9;
    localparam int DEF_CHANEL     = 3;

    // Weights for all channels plus one trailing bias word.
    function automatic int calc_wpf(input int ksize, input int chanel);
        return ksize * chanel + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISH    = 3'd4
    } load_state_t;

endpackage

// File: rtl/kernel_weight_ram.sv
// Kernel weight/bias store: one write port, one synchronous read port with read enable.
module kernel_weight_ram
    import cnn_kernel_pkg::*;
#(
    parameter int DEPTH = 112,
    parameter int WIDTH = DEF_DATA_WIDTH,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; with re low it holds the last word read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/kernel_stream_loader.sv
// Streams each filter's weights and bias from on-chip RAM, then waits for that filter's done.
// Optional WAIT_DONE timeout enabled by defining KERNEL_LOAD_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | host may write RAM; waiting for start
// FETCH        | first RAM read of the filter in flight
// STREAM       | one word per cycle on kernel with load_kernel strobe
// WAIT_DONE    | waiting for load_kernel_done_in[f]
// FINISH       | done pulse, back to IDLE
module kernel_stream_loader
    import cnn_kernel_pkg::*;
#(
    parameter int NUM_FILTERS    = 4,
    parameter int CHANEL         = DEF_CHANEL,
    parameter int KSIZE          = DEF_KSIZE,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int WPF    = calc_wpf(KSIZE, CHANEL),
    localparam int DEPTH  = NUM_FILTERS * WPF,
    localparam int ADDR_W = $clog2(DEPTH)
)(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_FILTERS-1:0] load_kernel,
    output logic [DATA_WIDTH-1:0]  kernel,
    input  logic [NUM_FILTERS-1:0] load_kernel_done_in,
    output logic                   error
);

    localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int WW = $clog2(WPF);
    localparam logic [FW-1:0] LAST_F = FW'(NUM_FILTERS - 1);
    localparam logic [WW-1:0] LAST_W = WW'(WPF - 1);

    load_state_t           state;
    logic [FW-1:0]         f_idx;
    logic [WW-1:0]         w_idx;
    logic [ADDR_W-1:0]     raddr;
    logic                  ram_we;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;

    // Filters are packed back to back, so raddr simply runs on across filters.
    assign ram_we = wr_en && (state == ST_IDLE);
    assign rd_en  = (state == ST_FETCH) || ((state == ST_STREAM) && (w_idx != LAST_W));
    assign kernel = rd_data;

    kernel_weight_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (ram_we),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .re     (rd_en),
        .raddr  (raddr),
        .rdata  (rd_data)
    );

`ifdef KERNEL_LOAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            f_idx       <= '0;
            w_idx       <= '0;
            raddr       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_kernel <= '0;
`ifdef KERNEL_LOAD_TIMEOUT_EN
            tmr         <= '0;
            error       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH;
                        f_idx <= '0;
                        w_idx <= '0;
                        raddr <= '0;
                        busy  <= 1'b1;
`ifdef KERNEL_LOAD_TIMEOUT_EN
                        error <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    state       <= ST_STREAM;
                    raddr       <= raddr + 1'b1;
                    load_kernel <= NUM_FILTERS'(1) << f_idx;
                end
                ST_STREAM: begin
                    if (w_idx == LAST_W) begin
                        state       <= ST_WAIT_DONE;
                        w_idx       <= '0;
                        load_kernel <= '0;
`ifdef KERNEL_LOAD_TIMEOUT_EN
                        tmr         <= TW'(TIMEOUT_CYCLES - 1);
`endif
                    end else begin
                        w_idx <= w_idx + 1'b1;
                        raddr <= raddr + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (load_kernel_done_in[f_idx]) begin
                        if (f_idx == LAST_F) begin
                            state <= ST_FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                            f_idx <= f_idx + 1'b1;
                        end
                    end
`ifdef KERNEL_LOAD_TIMEOUT_EN
                    else if (tmr == '0) begin
                        state <= ST_FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
`endif
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_stream_loader.sv
// Scoreboard bench for kernel_stream_loader with behavioural filter and RAM models.
module tb_kernel_stream_loader;
    import cnn_kernel_pkg::*;

    localparam int NF    = 4;
    localparam int WPF   = 28;
    localparam int DEPTH = NF * WPF;
    localparam int AW    = 7;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic [NF-1:0] load_kernel;
    logic [NF-1:0] ldone = '0;
    logic [31:0]   kernel;

    kernel_stream_loader #(.NUM_FILTERS(NF), .TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .load_kernel         (load_kernel),
        .kernel              (kernel),
        .load_kernel_done_in (ldone),
        .error               (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic last_rst = 1'b1;
    always @(posedge clk) last_rst <= !resetn;

    // Filter model: sticky done after WPF strobes plus a per-filter delay.
    int   fcnt [NF];
    int   fpend[NF];
    int   fdly [NF];
    bit   fhold[NF];
    logic flt_clr = 1'b0;

    always @(posedge clk) begin
        for (int f = 0; f < NF; f++) begin
            if (!resetn || flt_clr) begin
                fcnt[f]  = 0;
                fpend[f] = 0;
                ldone[f] <= 1'b0;
            end else begin
                if (fpend[f] > 0) begin
                    fpend[f]--;
                    if (fpend[f] == 0 && !fhold[f]) ldone[f] <= 1'b1;
                end
                if (load_kernel[f]) begin
                    fcnt[f]++;
                    if (fcnt[f] == WPF && !fhold[f]) begin
                        if (fdly[f] == 0) ldone[f] <= 1'b1;
                        else fpend[f] = fdly[f];
                    end
                end
            end
        end
    end

    typedef struct {
        int          cyc;
        logic [3:0]  lk;
        logic [31:0] data;
    } beat_t;

    beat_t       bq[$];
    int          dq[$];
    beat_t       mb;
    logic [31:0] mem_m[DEPTH];
    bit          stk[NF];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    bit         mon_en = 1'b0;
    int         busy_lo = 1;
    int         busy_hi = 0;
    logic [3:0] prev_lk = '0;
    logic [31:0] prev_k = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (load_kernel != '0) begin
                if (bq.size() == 0) begin
                    chk("unexpected_beat", 64'(load_kernel), 64'd0);
                end else begin
                    mb = bq.pop_front();
                    chk("beat_cycle", 64'(cyc), 64'(mb.cyc));
                    chk("beat_strobe", 64'(load_kernel), 64'(mb.lk));
                    chk("beat_word", 64'(kernel), 64'(mb.data));
                end
            end else if (prev_lk != '0 && !last_rst) begin
                chk("kernel_hold", 64'(kernel), 64'(prev_k));
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
            end
            chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
`ifndef KERNEL_LOAD_TIMEOUT_EN
            chk("error_tied", 64'(error), 64'd0);
`endif
            prev_lk = load_kernel;
            prev_k  = kernel;
        end
    end

    // Reference timing: a filter streams WPF words from t, its done arrives 1+delay after the
    // bias (immediately if still sticky), the next filter starts two cycles after that.
    task automatic gen_expect(input int base, input int hold_f, input int cut, output int done_cyc);
        int    t;
        int    ex;
        beat_t b;
        t  = base + 2;
        ex = t;
        for (int f = 0; f < NF; f++) begin
            for (int w = 0; w < WPF; w++) begin
                b.cyc  = t + w;
                b.lk   = 4'(1 << f);
                b.data = mem_m[f * WPF + w];
                if (cut < 0 || b.cyc <= base + cut) bq.push_back(b);
            end
            if (f == hold_f) begin
                ex = t + WPF - 1 + TO;
                break;
            end
            ex     = t + WPF + (stk[f] ? 0 : fdly[f]);
            stk[f] = 1'b1;
            t      = ex + 2;
        end
        done_cyc = ex + 1;
        if (cut < 0) dq.push_back(done_cyc);
    endtask

    task automatic recover();
        bq.delete();
        dq.delete();
        @(negedge clk) resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
        for (int f = 0; f < NF; f++) stk[f] = 1'b0;
    endtask

    task automatic run(input bit noise, input bit wr_at_start, input int hold_f);
        int base;
        int dc;
        int a;
        @(negedge clk);
        base = cyc;
        if (wr_at_start) begin
            a          = int'($urandom_range(0, DEPTH - 1));
            wr_en      = 1'b1;
            wr_addr    = AW'(a);
            wr_data    = $urandom;
            mem_m[a]   = wr_data;
        end
        start = 1'b1;
        gen_expect(base, hold_f, -1, dc);
        busy_lo = base + 1;
        busy_hi = dc - 1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
`ifdef KERNEL_LOAD_TIMEOUT_EN
        chk("error_cleared", 64'(error), 64'd0);
`endif
        while (cyc < dc + 3) begin
            if (noise && cyc < dc - 1) begin
                start   = 1'($urandom_range(0, 1));
                wr_en   = 1'($urandom_range(0, 1));
                wr_addr = '0;
                wr_data = 32'hDEAD;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk("pending_beats", 64'(bq.size()), 64'd0);
        chk("pending_done", 64'(dq.size()), 64'd0);
`ifdef KERNEL_LOAD_TIMEOUT_EN
        chk("error_flag", 64'(error), 64'(hold_f >= 0));
`endif
        if (bq.size() != 0 || dq.size() != 0) recover();
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en    = 1'b1;
            wr_addr  = AW'(i);
            wr_data  = rnd ? $urandom : 32'(i + 1);
            mem_m[i] = wr_data;
        end
        @(negedge clk) wr_en = 1'b0;
    endtask

    task automatic clear_filters();
        @(negedge clk) flt_clr = 1'b1;
        @(negedge clk) flt_clr = 1'b0;
        for (int f = 0; f < NF; f++) stk[f] = 1'b0;
    endtask

    task automatic reset_mid_stream();
        int base;
        int dc;
        @(negedge clk);
        base  = cyc;
        start = 1'b1;
        gen_expect(base, -1, 10, dc);
        busy_lo = base + 1;
        busy_hi = base + 10;
        @(negedge clk) start = 1'b0;
        while (cyc < base + 10) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rst_load_kernel", 64'(load_kernel), 64'd0);
        chk("rst_kernel", 64'(kernel), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pending_beats", 64'(bq.size()), 64'd0);
        bq.delete();
        for (int f = 0; f < NF; f++) stk[f] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int f = 0; f < NF; f++) begin
            fdly[f]  = 0;
            fhold[f] = 1'b0;
            stk[f]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        chk("reset_load_kernel", 64'(load_kernel), 64'd0);
        chk("reset_kernel", 64'(kernel), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        mon_en = 1'b1;

        fill(1'b0);
        clear_filters();
        run(1'b0, 1'b0, -1);

        clear_filters();
        fdly[1] = 5;
        run(1'b0, 1'b0, -1);
        fdly[1] = 0;

        run(1'b1, 1'b0, -1);
        run(1'b0, 1'b0, -1);

        reset_mid_stream();
        run(1'b0, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            fill(1'b1);
            clear_filters();
            for (int f = 0; f < NF; f++) fdly[f] = int'($urandom_range(0, 6));
            run(1'($urandom_range(0, 1)), 1'b1, -1);
            run(1'b0, 1'b0, -1);
        end

`ifdef KERNEL_LOAD_TIMEOUT_EN
        clear_filters();
        for (int f = 0; f < NF; f++) fdly[f] = 0;
        fhold[2] = 1'b1;
        run(1'b0, 1'b0, 2);
        fhold[2] = 1'b0;
        clear_filters();
        run(1'b0, 1'b0, -1);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
